// File: rtl/snn_spike_decoder.sv
// Rate decoder for the SNN output layer.
// Counts spikes per channel over a window of valid execute steps. It then scans the
// counters one per cycle and reports the argmax class, its count and a tie flag.
module snn_spike_decoder #(
    parameter int CHANNELS    = 8,
    parameter int COUNT_BITS  = 8,
    parameter int WINDOW_BITS = 8,
    localparam int IDX_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WINDOW_BITS-1:0] window_len,
    input  logic                   spike_valid,
    input  logic [CHANNELS-1:0]    spikes,
    input  logic [IDX_BITS-1:0]    count_sel,
    output logic [COUNT_BITS-1:0]  count_out,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_BITS-1:0]    class_idx,
    output logic [COUNT_BITS-1:0]  max_count,
    output logic                   tie
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_BITS-1:0]  CNT_ZERO = {COUNT_BITS{1'b0}};
    localparam logic [COUNT_BITS-1:0]  CNT_ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_BITS-1:0]  CNT_MAX  = {COUNT_BITS{1'b1}};
    localparam logic [WINDOW_BITS-1:0] WIN_ZERO = {WINDOW_BITS{1'b0}};
    localparam logic [WINDOW_BITS-1:0] WIN_ONE  = {{(WINDOW_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0]    IDX_ZERO = {IDX_BITS{1'b0}};
    localparam logic [IDX_BITS-1:0]    IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0]    IDX_LAST = IDX_BITS'(CHANNELS - 1);

    state_t                  state_r;
    logic [COUNT_BITS-1:0]   cnt_r [CHANNELS];
    logic [WINDOW_BITS-1:0]  sample_r;
    logic [WINDOW_BITS-1:0]  win_len_r;
    logic [IDX_BITS-1:0]     scan_idx_r;
    logic [COUNT_BITS-1:0]   best_cnt_r;
    logic [IDX_BITS-1:0]     best_idx_r;
    logic                    best_tie_r;
    logic                    busy_r;
    logic                    result_valid_r;
    logic [IDX_BITS-1:0]     class_idx_r;
    logic [COUNT_BITS-1:0]   max_count_r;
    logic                    tie_r;

    logic [WINDOW_BITS-1:0]  sample_next_s;
    logic [COUNT_BITS-1:0]   scan_cnt_s;
    logic [COUNT_BITS-1:0]   step_cnt_s;
    logic [IDX_BITS-1:0]     step_idx_s;
    logic                    step_tie_s;

    assign count_out    = cnt_r[count_sel];
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign class_idx    = class_idx_r;
    assign max_count    = max_count_r;
    assign tie          = tie_r;

    assign sample_next_s = sample_r + WIN_ONE;
    assign scan_cnt_s    = cnt_r[scan_idx_r];

    // One scan step: fold counter[scan_idx] into the running best (lowest index wins ties)
    always_comb begin
        step_cnt_s = best_cnt_r;
        step_idx_s = best_idx_r;
        step_tie_s = best_tie_r;
        if (scan_idx_r == IDX_ZERO) begin
            step_cnt_s = scan_cnt_s;
            step_idx_s = IDX_ZERO;
            step_tie_s = 1'b0;
        end else if (scan_cnt_s > best_cnt_r) begin
            step_cnt_s = scan_cnt_s;
            step_idx_s = scan_idx_r;
            step_tie_s = 1'b0;
        end else if (scan_cnt_s == best_cnt_r) begin
            step_tie_s = 1'b1;
        end else begin
            step_tie_s = best_tie_r;
        end
    end

    // Control FSM, spike counters, scan datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            sample_r       <= WIN_ZERO;
            win_len_r      <= WIN_ZERO;
            scan_idx_r     <= IDX_ZERO;
            best_cnt_r     <= CNT_ZERO;
            best_idx_r     <= IDX_ZERO;
            best_tie_r     <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            class_idx_r    <= IDX_ZERO;
            max_count_r    <= CNT_ZERO;
            tie_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            cnt_r[i] <= CNT_ZERO;
                        end
                        sample_r   <= WIN_ZERO;
                        win_len_r  <= window_len;
                        scan_idx_r <= IDX_ZERO;
                        busy_r     <= 1'b1;
                        // An empty window skips accumulation and scans all-zero counters
                        if (window_len == WIN_ZERO) begin
                            state_r <= ST_SCAN;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (spike_valid) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (spikes[i] && (cnt_r[i] != CNT_MAX)) begin
                                cnt_r[i] <= cnt_r[i] + CNT_ONE;
                            end
                        end
                        sample_r <= sample_next_s;
                        if (sample_next_s == win_len_r) begin
                            scan_idx_r <= IDX_ZERO;
                            state_r    <= ST_SCAN;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= ST_ACCUM;
                    end
                end
                ST_SCAN: begin
                    best_cnt_r <= step_cnt_s;
                    best_idx_r <= step_idx_s;
                    best_tie_r <= step_tie_s;
                    // The last step's result is loaded straight into the outputs shown in DONE
                    if (scan_idx_r == IDX_LAST) begin
                        class_idx_r    <= step_idx_s;
                        max_count_r    <= step_cnt_s;
                        tie_r          <= step_tie_s;
                        result_valid_r <= 1'b1;
                        state_r        <= ST_DONE;
                    end else begin
                        scan_idx_r <= scan_idx_r + IDX_ONE;
                        state_r    <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= ST_IDLE;
                end
                default: begin
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/snn_spike_decoder.md
Name: snn_spike_decoder

Overview:
- Rate-decoding stage directly downstream of the SNN core's output spike layer, on the same `clk`.
- Counts spikes per output neuron over a programmable window of valid execute steps.
- Then scans the counters sequentially and reports the winning class (argmax), its count and a tie flag.
- Gives the host a single classification result instead of raw per-step spike bits.

Parameters:
- CHANNELS, 8: number of spike channels, equal to the output-layer neuron count.
- COUNT_BITS, 8: width of each per-channel saturating spike counter.
- WINDOW_BITS, 8: width of the window-length and sample counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a new decode window; sampled only in IDLE
- window_len  input  WINDOW_BITS  number of valid samples per window; sampled on accepted start
- spike_valid  input  1  high on cycles where `spikes` is a valid execute step (tied to execute)
- spikes  input  CHANNELS  output-layer spike vector, bit i = neuron i
- count_sel  input  $clog2(CHANNELS)  channel select for count readout
- count_out  output  COUNT_BITS  combinational view of counter[count_sel]
- busy  output  1  high in every state except IDLE
- result_valid  output  1  one-cycle pulse when a result is presented
- class_idx  output  $clog2(CHANNELS)  winning channel
- max_count  output  COUNT_BITS  count of the winning channel
- tie  output  1  another channel equals max_count

Behaviour:
- Synchronous, active-high reset. Applies in any state, including mid-window or mid-scan.
  - State returns to IDLE.
  - All counters, sample counter and scan index clear to 0.
  - busy=0, result_valid=0, class_idx=0, max_count=0, tie=0.
- IDLE → ACCUM on start=1:
  - Clear all channel counters and the sample counter.
  - Latch window_len.
  - If the latched window_len is 0, go directly to SCAN with all counters zero.
- start is ignored in ACCUM, SCAN and DONE.
- ACCUM, each cycle with spike_valid=1:
  - counter[i] increments for every spikes[i]=1, saturating at 2^COUNT_BITS-1 (no wrap).
  - The sample counter increments.
  - When the sample counter reaches the latched window_len on this edge, next state is SCAN with scan index 0.
- ACCUM, cycles with spike_valid=0: nothing changes; gaps do not count toward the window.
- Spikes are not captured outside ACCUM. spike_valid/spikes arriving in IDLE, SCAN or DONE are dropped.
- SCAN visits one channel per cycle, idx 0..CHANNELS-1:
  - idx 0 initialises best_count=counter[0], best_idx=0, tie=0.
  - idx>0, counter[idx] > best_count: replace best, tie=0.
  - idx>0, counter[idx] == best_count: tie=1, best_idx unchanged (lowest index wins ties).
  - After idx=CHANNELS-1, go to DONE.
- DONE lasts exactly one cycle, then IDLE:
  - class_idx, max_count and tie are updated from the scan result.
  - result_valid=1.
- class_idx, max_count and tie hold their values until the next DONE or reset. They are not cleared by start.
- Latency: if the last valid sample is accepted at the edge ending cycle T, SCAN occupies cycles T+1..T+CHANNELS and result_valid=1 in cycle T+CHANNELS+1.
  - With window_len=0 and start in cycle S, result_valid=1 in cycle S+CHANNELS+1.
- count_out reflects live counter contents in every state, including during accumulation.
- All-zero window: class_idx=0, max_count=0, tie=1 whenever CHANNELS>1.

Test Plan:
- Reset mid-window: reset=1 during ACCUM after 5 samples → next cycle busy=0, count_out=0 for all count_sel, all outputs 0. A following start works normally.
- Basic decode: window_len=4; spikes=8'b0000_0100 on 4 consecutive valid cycles → result_valid 9 cycles after the last sample; class_idx=2, max_count=4, tie=0.
- Gaps and ties: window_len=3; valid samples 8'b1000_0001, 8'b1000_0001, 8'b0000_0000 interleaved with spike_valid=0 cycles → class_idx=0, max_count=2, tie=1. Gap cycles do not advance the window.
- Saturation: COUNT_BITS=8, window_len=255 then repeat; spikes=8'hFF throughout → max_count=255, tie=1. Verify no wrap with COUNT_BITS=4, window_len=20 → max_count=15.
- Zero window and ignored start: window_len=0 start → result_valid exactly 9 cycles later, class_idx=0, max_count=0, tie=1. A start asserted during SCAN is ignored (busy stays 1, single result_valid pulse).
- Later larger channel clears tie: counts {3,3,5,...} → class_idx=2, max_count=5, tie=0.
